// File: rtl/div_pkg.sv
// Shared types and constants for the execute-stage divide sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_ITER);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial-subtract divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    borrow  = trial[WIDTH];
    rem_o   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer producing {hi=remainder, lo=quotient}.
// Optional DIV_EARLY_OUT_EN skips iteration for zero divisors and |dividend| < |divisor|.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               stall,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             early;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] hi, lo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    accept = (state_q == IDLE) && start && !annul;
    mag_a  = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
`ifdef DIV_EARLY_OUT_EN
    early  = (divisor == '0) || (mag_a < mag_b);
`else
    early  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = early ? DONE : BUSY;
      BUSY: begin
        if (annul)                  state_d = IDLE;
        else if (count_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Early-out preloads the remainder with |dividend| so the common sign fixup yields rem = dividend.
  always_comb begin
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    if (accept) begin
      count_d = '0;
      rem_d   = early ? mag_a : '0;
      quo_d   = early ? '0 : mag_a;
      dvs_d   = mag_b;
      dvd_d   = dividend;
      negq_d  = signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      negr_d  = signed_div && dividend[WIDTH-1];
      dz_d    = (divisor == '0);
    end else if (state_q == BUSY) begin
      if (annul) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
        rem_d   = step_rem;
        quo_d   = step_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    stall        = accept || (state_q == BUSY);
    result_valid = (state_q == DONE) && !annul;
    if (dz_q) begin
      hi = dvd_q;
      lo = {WIDTH{1'b1}};
    end else begin
      hi = negr_q ? -rem_q : rem_q;
      lo = negq_q ? -quo_q : quo_q;
    end
    result = {hi, lo};
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides, annul, reset and timing windows.
module tb_div_seq;

  localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic           annul;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           stall;
  logic           result_valid;
  logic [2*W-1:0] result;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .annul        (annul),
    .dividend     (dividend),
    .divisor      (divisor),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every result_valid pops one expectation
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(result_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " result"}, result, e.res);
        check({e.name, " valid_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge following DONE.
  task automatic issue(input string nm, input logic sd, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat);
    int ns  = 0;
    bit got = 1'b0;
    start      = 1'b1;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    sb.push_back('{exp, cyc + lat, nm});
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (stall) ns++;
      if (result_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({nm, " valid_seen"}, 64'(got), 64'd1);
    check({nm, " stall_cycles"}, 64'(ns), 64'(lat));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int nv;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall", 64'(stall), 64'd0);
    check("reset valid", 64'(result_valid), 64'd0);
    check("reset result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1);

    // back-to-back directed vectors
    issue("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33);
    issue("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   33);
    issue("div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000},   33);
    issue("divu_5_0",     1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFFFFFF},   EO_LAT);
    issue("div_m5_0",     1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB,   32'hFFFFFFFF},   EO_LAT);
    issue("divu_3_10",    1'b0, 32'd3,          32'd10,         {32'd3,          32'd0},          EO_LAT);
    issue("div_m3_10",    1'b1, 32'hFFFFFFFD,   32'd10,         {32'hFFFFFFFD,   32'd0},          EO_LAT);
    issue("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   33);
    issue("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF},   33);
    issue("div_m100_m7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE,   32'd14},         33);
    issue("divu_big",     1'b0, 32'hFFFFFFFF,   32'h80000000,   {32'h7FFFFFFF,   32'd1},          33);
    idle_cycles(2);

    // annul together with start in IDLE: no accept
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; dividend = 32'd40; divisor = 32'd4;
    @(negedge clk);
    check("annul_start stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("annul_start no_busy", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // annul at cycle 10 of a running divide
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    idle_cycles(10);
    start = 1'b0; annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul stall_drop", 64'(stall), 64'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) nv++;
    end
    check("annul no_valid", 64'(nv), 64'd0);
    @(posedge clk); #1;
    issue("divu_9_3_post_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    idle_cycles(1);

    // reset in cycle 20 of a running divide
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    idle_cycles(20);
    rst = 1'b1; start = 1'b0;
    #1;
    check("midrst stall", 64'(stall), 64'd0);
    check("midrst valid", 64'(result_valid), 64'd0);
    check("midrst result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(40);
    issue("divu_1000_3_post_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);
    idle_cycles(3);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
